uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receive half of the podule UART: the far end of the SERIAL_TXD path. It
//  oversamples the asynchronous SERIAL_RXD line 16x and deframes 8N1 characters into
//  a show-ahead FIFO that the host reads through the uart_cs register window. It drives
//  uart_rx_irq to the interrupts block and SERIAL_RTS for hardware flow control.
// PARAMETERS
//  FIFO_DEPTH   16   receive FIFO entries; power of 2, >=4
//  IRQ_LEVEL    8    rx_irq asserts when fifo_count >= IRQ_LEVEL (1..FIFO_DEPTH)
//  TIMEOUT_CH   4    idle-timeout length in character times (1 char = 160 ticks)
// PORTS
//  clk          in   1   main clock (FPGA_CLK)
//  rst          in   1   asynchronous, active-high reset
//  rxd          in   1   SERIAL_RXD, asynchronous to clk
//  divisor      in   16  clk cycles per 16x tick; 0 treated as 1
//  rd_stb       in   1   one-cycle host read pulse: pops FIFO head
//  clr_err      in   1   one-cycle pulse: clears overrun/frame_err/brk
//  rd_data      out  8   FIFO head (show-ahead); 0 when empty
//  rx_avail     out  1   FIFO non-empty
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  entries held
//  overrun      out  1   sticky: byte arrived with FIFO full
//  frame_err    out  1   sticky: stop bit sampled low
//  brk          out  1   sticky: break detected
//  rx_irq       out  1   level: (fifo_count>=IRQ_LEVEL) | timeout
//  rts          out  1   1 = peer may send
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, all outputs 0 except rts=1; rxd synchroniser preset to 1.
//  rxd passes through a 2-FF synchroniser; 'line' = synchronised value (2-cycle latency).
//  Tick generator: counter reloads with divisor-1; tick pulses 1 cycle on reaching 0.
//  Divisor changes take effect at the next reload.
//  FSM advances only on tick; sub-bit counter sc[3:0]:
//   IDLE:  line==0 -> START, sc=0.
//   START: at sc==7 sample; line==1 -> IDLE (glitch rejected); else sc=0, bit=0 -> DATA.
//   DATA:  at sc==15 sample into shift reg, LSB first; after bit 7 -> STOP.
//   STOP:  at sc==15 sample. 1: push byte -> IDLE. 0 with data!=0: push byte, set
//          frame_err -> IDLE. 0 with data==0: set brk, no push -> WAIT_HI.
//   WAIT_HI: line==1 -> IDLE (no new start until the line is marked).
//  Push occurs in the clk cycle after the STOP sample tick.
//  FIFO: push when full without rd_stb -> byte dropped, overrun set.
//   push+rd_stb same cycle, FIFO full: both happen, count unchanged, no overrun.
//   push+rd_stb same cycle, FIFO empty: push only, rd_stb ignored.
//   rd_stb when empty: no effect. Pointers wrap modulo FIFO_DEPTH.
//  rd_data valid the cycle after a push or pop (registered read address).
//  Sticky flags: clr_err clears; a set in the same cycle as clr_err wins.
//  Timeout: counter of ticks since the last push or pop; clears on either. Expires at
//   TIMEOUT_CH*160 ticks while rx_avail; timeout flag stays set until the next push/pop
//   or until FIFO empty.
//  rts: cleared when fifo_count >= FIFO_DEPTH-4; set when fifo_count <= FIFO_DEPTH/2;
//   holds otherwise.
//  rst mid-character: FSM and FIFO return to reset state immediately; partial byte lost.
// STRUCTURE
//  uart_defs.vh (shared with uart_tx): FSM state encodings, OVERSAMPLE=16,
//   MID_SAMPLE=7, CHAR_TICKS=160.
//  Sub-module uart_rx_fifo: sync FIFO with show-ahead read and count; instantiated here.
//  Tick generator, synchroniser, FSM, flags, timeout and rts logic stay in uart_rx.
// TESTING
//  1 divisor=4, send 0xA5 8N1 at 64 clk/bit -> rx_avail=1, rd_data=0xA5, count=1,
//    no error flags.
//  2 Low pulse of 3 ticks on an idle line -> FSM back to IDLE, nothing pushed.
//  3 Send 17 bytes 0x00..0x10 with no reads (depth 16) -> count=16, overrun=1,
//    rts=0 after the 12th byte, rd_data=0x00.
//    Pop 8 -> rts=1 once count<=8. clr_err -> overrun=0.
//  4 Send 0x3C with stop bit 0 -> byte pushed, frame_err=1.
//    Hold rxd low for 2 chars -> brk=1, no push, no new byte until rxd goes high.
//  5 Send 2 bytes, idle for 4 chars -> rx_irq=1 (timeout). Pop -> timeout clears;
//    rx_irq re-asserts after another 640 ticks.
//    8 bytes -> rx_irq=1 via level.
//  6 Assert rst mid DATA -> all outputs at reset values. Next clean byte 0x5A is
//    received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
// Contents: receiver FSM state encoding, oversampling constants and the
// tick-counter reload helper used by the baud tick generator.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HI
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int CHAR_TICKS = 160;

  // A divisor of 0 behaves as 1, so the counter reloads with 0 and ticks every cycle.
  function automatic logic [15:0] reload_value(input logic [15:0] divisor);
    return (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with registered show-ahead head and entry count.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push/wdata: write request and byte
//   pop       : read request (ignored when empty)
//   rdata     : head entry, valid the cycle after a push/pop; 0 when empty
//   count     : entries held
//   overflow  : push refused because the FIFO was full and not popping
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic [AW:0]   count,
  output logic          overflow
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_n;
  logic [AW:0]   count_n;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;
  assign rd_ptr_n = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      // The new head may be the byte being written this cycle (bypass the array).
      if (count_n == '0)
        rdata <= '0;
      else if (do_push && (rd_ptr_n == wr_ptr))
        rdata <= wdata;
      else
        rdata <= mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 deframer feeding a show-ahead FIFO.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   rxd        : asynchronous serial input
//   divisor    : clk cycles per 16x tick (0 acts as 1)
//   rd_stb     : pop FIFO head;  clr_err : clear sticky error flags
//   rd_data    : FIFO head (0 when empty); rx_avail : FIFO non-empty
//   fifo_count : entries held
//   overrun, frame_err, brk : sticky status flags
//   rx_irq     : FIFO level reached or idle timeout
//   rts        : flow control, 1 = peer may send
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int IRQ_LEVEL  = 8,
  parameter int TIMEOUT_CH = 4,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxd,
  input  logic [15:0]   divisor,
  input  logic          rd_stb,
  input  logic          clr_err,
  output logic [7:0]    rd_data,
  output logic          rx_avail,
  output logic [CW-1:0] fifo_count,
  output logic          overrun,
  output logic          frame_err,
  output logic          brk,
  output logic          rx_irq,
  output logic          rts
);

  localparam int TO_LIMIT = TIMEOUT_CH * CHAR_TICKS;

  logic [1:0]  sync_q;
  logic        line;
  logic [15:0] tick_cnt;
  logic        tick;
  rx_state_t   state, state_n;
  logic [3:0]  sc, sc_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shift, shift_n;
  logic        push_n, frame_n, brk_n;
  logic        push_q, frame_q, brk_q;
  logic        overflow;
  logic        pop_eff;
  logic [15:0] to_cnt;
  logic        timeout;

  // Stage: input synchroniser, preset to the idle (marking) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxd};
  end
  assign line = sync_q[1];

  // Stage: 16x tick generator; a new divisor is picked up on the next reload.
  assign tick = (tick_cnt == 16'd0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= 16'd0;
    else if (tick) tick_cnt <= reload_value(divisor);
    else           tick_cnt <= tick_cnt - 1'b1;
  end

  // Stage: deframing FSM, advancing only on ticks.
  always_comb begin
    state_n = state;
    sc_n    = sc;
    bit_n   = bit_idx;
    shift_n = shift;
    push_n  = 1'b0;
    frame_n = 1'b0;
    brk_n   = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!line) begin
            state_n = ST_START;
            sc_n    = 4'd0;
          end
        end
        ST_START: begin
          if (sc == 4'(MID_SAMPLE)) begin
            if (line) begin
              state_n = ST_IDLE;
            end else begin
              sc_n    = 4'd0;
              bit_n   = 3'd0;
              state_n = ST_DATA;
            end
          end else begin
            sc_n = sc + 1'b1;
          end
        end
        ST_DATA: begin
          if (sc == 4'(OVERSAMPLE - 1)) begin
            shift_n = {line, shift[7:1]};
            sc_n    = 4'd0;
            if (bit_idx == 3'd7) state_n = ST_STOP;
            else                 bit_n   = bit_idx + 1'b1;
          end else begin
            sc_n = sc + 1'b1;
          end
        end
        ST_STOP: begin
          if (sc == 4'(OVERSAMPLE - 1)) begin
            if (line) begin
              push_n  = 1'b1;
              state_n = ST_IDLE;
            end else if (shift != 8'd0) begin
              push_n  = 1'b1;
              frame_n = 1'b1;
              state_n = ST_IDLE;
            end else begin
              // All-zero character with a low stop bit is a break: hold off
              // new starts until the line returns to marking.
              brk_n   = 1'b1;
              state_n = ST_WAIT_HI;
            end
          end else begin
            sc_n = sc + 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (line) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sc      <= 4'd0;
      bit_idx <= 3'd0;
      push_q  <= 1'b0;
      frame_q <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state   <= state_n;
      sc      <= sc_n;
      bit_idx <= bit_n;
      push_q  <= push_n;
      frame_q <= frame_n;
      brk_q   <= brk_n;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

  // Stage: FIFO push, one cycle after the stop-bit sample.
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_q),
    .wdata    (shift),
    .pop      (rd_stb),
    .rdata    (rd_data),
    .count    (fifo_count),
    .overflow (overflow)
  );

  assign rx_avail = (fifo_count != '0);
  assign pop_eff  = rd_stb && rx_avail;

  // Stage: sticky flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      brk       <= 1'b0;
    end else begin
      if (overflow)     overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (frame_q)      frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (brk_q)        brk <= 1'b1;
      else if (clr_err) brk <= 1'b0;
    end
  end

  // Stage: idle timeout; the counter saturates at the limit and holds there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= 16'd0;
    else if (push_q || pop_eff || !rx_avail)
      to_cnt <= 16'd0;
    else if (tick && (to_cnt != 16'(TO_LIMIT)))
      to_cnt <= to_cnt + 1'b1;
  end
  assign timeout = rx_avail && (to_cnt == 16'(TO_LIMIT));
  assign rx_irq  = (fifo_count >= CW'(IRQ_LEVEL)) || timeout;

  // Stage: flow control with hysteresis between the two thresholds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rts <= 1'b1;
    else if (fifo_count >= CW'(FIFO_DEPTH - 4))
      rts <= 1'b0;
    else if (fifo_count <= CW'(FIFO_DEPTH / 2))
      rts <= 1'b1;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives 8N1 frames at divisor 4 (64 clk per bit),
// queues every byte that must land in the FIFO, and a read-port monitor
// compares each popped head against that queue.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [15:0] divisor = 16'd4;
  logic        rd_stb = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  rd_data;
  logic        rx_avail;
  logic [4:0]  fifo_count;
  logic        overrun, frame_err, brk, rx_irq, rts;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  localparam int BIT_CLK = 64;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .divisor    (divisor),
    .rd_stb     (rd_stb),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rx_avail   (rx_avail),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .brk        (brk),
    .rx_irq     (rx_irq),
    .rts        (rts)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame: start, 8 data bits LSB first, stop. A bad stop is held low only
  // through its sampling point so the following idle is clean.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic expect_push);
    if (expect_push) exp_q.push_back(b);
    rxd = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clk(BIT_CLK);
    end
    if (stop_ok) begin
      rxd = 1'b1;
      wait_clk(BIT_CLK);
    end else begin
      rxd = 1'b0;
      wait_clk(48);
      rxd = 1'b1;
      wait_clk(16);
    end
  endtask

  task automatic pop();
    rd_stb = 1'b1;
    wait_clk(1);
    rd_stb = 1'b0;
    wait_clk(2);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
    wait_clk(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_data"},   rd_data, 0);
    check({tag, "_rx_avail"},  rx_avail, 0);
    check({tag, "_count"},     fifo_count, 0);
    check({tag, "_overrun"},   overrun, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_brk"},       brk, 0);
    check({tag, "_rx_irq"},    rx_irq, 0);
    check({tag, "_rts"},       rts, 1);
  endtask

  // Monitor: every effective pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rd_stb && rx_avail) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {24'd0, rd_data}, 32'hFFFF_FFFF);
      end else begin
        check("pop_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);
    check_reset_outputs("reset");

    // Single clean byte
    send_byte(8'hA5, 1'b1, 1'b1);
    wait_clk(4);
    check("t1_avail", rx_avail, 1);
    check("t1_data", rd_data, 8'hA5);
    check("t1_count", fifo_count, 1);
    check("t1_overrun", overrun, 0);
    check("t1_frame", frame_err, 0);
    check("t1_brk", brk, 0);
    pop();
    check("t1_empty_count", fifo_count, 0);
    check("t1_empty_data", rd_data, 0);

    // Short low glitch is rejected
    rxd = 1'b0;
    wait_clk(12);
    rxd = 1'b1;
    wait_clk(200);
    check("t2_count", fifo_count, 0);
    check("t2_frame", frame_err, 0);

    // Fill past depth, check flow control and overrun
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), 1'b1, i < 16);
      if (i == 10) check("t3_rts_11", rts, 1);
      if (i == 11) check("t3_rts_12", rts, 0);
    end
    wait_clk(2);
    check("t3_count", fifo_count, 16);
    check("t3_overrun", overrun, 1);
    check("t3_head", rd_data, 8'h00);
    check("t3_rts_full", rts, 0);
    check("t3_irq_level", rx_irq, 1);
    for (int i = 0; i < 7; i++) pop();
    check("t3_rts_hold", rts, 0);
    pop();
    check("t3_count_8", fifo_count, 8);
    check("t3_rts_back", rts, 1);
    pulse_clr();
    check("t3_overrun_clr", overrun, 0);
    for (int i = 0; i < 8; i++) pop();
    check("t3_drained", fifo_count, 0);

    // Framing error, then break
    send_byte(8'h3C, 1'b0, 1'b1);
    wait_clk(4);
    check("t4_count", fifo_count, 1);
    check("t4_frame", frame_err, 1);
    check("t4_brk_clear", brk, 0);
    pop();
    pulse_clr();
    check("t4_frame_clr", frame_err, 0);
    rxd = 1'b0;
    wait_clk(2 * 10 * BIT_CLK);
    check("t4_brk", brk, 1);
    check("t4_brk_nopush", fifo_count, 0);
    check("t4_brk_noframe", frame_err, 0);
    rxd = 1'b1;
    wait_clk(200);
    check("t4_after_high", fifo_count, 0);
    pulse_clr();
    check("t4_brk_clr", brk, 0);

    // Idle timeout and level interrupt
    send_byte(8'h11, 1'b1, 1'b1);
    send_byte(8'h22, 1'b1, 1'b1);
    wait_clk(2);
    check("t5_irq_early", rx_irq, 0);
    wait_clk(2400);
    check("t5_irq_before_to", rx_irq, 0);
    wait_clk(300);
    check("t5_irq_timeout", rx_irq, 1);
    pop();
    check("t5_irq_cleared", rx_irq, 0);
    wait_clk(2400);
    check("t5_irq_before_to2", rx_irq, 0);
    wait_clk(300);
    check("t5_irq_timeout2", rx_irq, 1);
    pop();
    check("t5_irq_empty", rx_irq, 0);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h30 + 8'(i), 1'b1, 1'b1);
      if (i == 6) check("t5_irq_7", rx_irq, 0);
    end
    wait_clk(2);
    check("t5_irq_level", rx_irq, 1);
    check("t5_count_8", fifo_count, 8);
    for (int i = 0; i < 8; i++) pop();

    // Reset in the middle of a character
    send_byte(8'h77, 1'b1, 1'b1);
    rxd = 1'b0;
    wait_clk(BIT_CLK);
    rxd = 1'b1;
    wait_clk(100);
    rst = 1'b1;
    exp_q.delete();
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    check_reset_outputs("t6_reset");
    send_byte(8'h5A, 1'b1, 1'b1);
    wait_clk(4);
    check("t6_data", rd_data, 8'h5A);
    check("t6_count", fifo_count, 1);
    check("t6_frame", frame_err, 0);
    pop();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
